// File: rtl/wt_mem_arbiter_pkg.sv
// Shared sizing helpers for the L1-to-memory arbiter and its round-robin picker.
package wt_mem_arbiter_pkg;

  // Port-ID field width; a single-port build still carries a 1-bit field.
  function automatic int port_id_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Credit counter width able to hold 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/wt_mem_arbiter_rr.sv
// Combinational round-robin picker: search starts one past the pointer and wraps.
module wt_mem_arb_rr #(
  parameter int NumPorts = 2,
  parameter int IdxW     = 1
) (
  input  logic [NumPorts-1:0] eligible,
  input  logic [IdxW-1:0]     ptr,
  output logic [NumPorts-1:0] grant,
  output logic [IdxW-1:0]     grant_idx,
  output logic                grant_vld
);

  int p;

  // NOTE: every output gets a default before the search loop so no path leaves a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    p         = 0;
    for (int i = 1; i <= NumPorts; i++) begin
      p = (int'(ptr) + i) % NumPorts;
      if (!grant_vld && eligible[p]) begin
        grant_vld = 1'b1;
        grant[p]  = 1'b1;
        grant_idx = IdxW'(p);
      end
    end
  end

endmodule

// File: rtl/wt_mem_arbiter.sv
// N-port round-robin arbiter from L1 cache clients onto a single memory adapter port,
// with per-port credit limits and return routing by a prepended port ID.
module wt_mem_arbiter
  import wt_mem_arbiter_pkg::*;
#(
  parameter int  NumPorts       = 2,
  parameter int  ReqWidth       = 128,
  parameter int  RtrnWidth      = 128,
  parameter int  TidWidth       = 2,
  parameter int  MaxOutstanding = 4,
  localparam int PortIdW        = port_id_w(NumPorts)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 stall_i,
  output logic                                 busy_o,
  output logic                                 err_o,
  input  logic [NumPorts-1:0]                  req_i,
  output logic [NumPorts-1:0]                  ack_o,
  input  logic [NumPorts-1:0][ReqWidth-1:0]    data_i,
  input  logic [NumPorts-1:0][TidWidth-1:0]    tid_i,
  output logic                                 mem_req_o,
  input  logic                                 mem_ack_i,
  output logic [ReqWidth-1:0]                  mem_data_o,
  output logic [PortIdW+TidWidth-1:0]          mem_tid_o,
  input  logic                                 mem_rtrn_vld_i,
  input  logic [PortIdW+TidWidth-1:0]          mem_rtrn_tid_i,
  input  logic [RtrnWidth-1:0]                 mem_rtrn_data_i,
  output logic [NumPorts-1:0]                  rtrn_vld_o,
  output logic [TidWidth-1:0]                  rtrn_tid_o,
  output logic [RtrnWidth-1:0]                 rtrn_data_o
);

  localparam int CntW = cnt_w(MaxOutstanding);

  typedef struct packed {
    logic [PortIdW-1:0]  port;
    logic [TidWidth-1:0] tid;
  } tagged_tid_t;

  typedef logic [CntW-1:0] cnt_t;

  cnt_t [NumPorts-1:0] cnt_q;
  logic [PortIdW-1:0]  ptr_q;
  logic                valid_q;
  logic [ReqWidth-1:0] data_q;
  tagged_tid_t         tag_q;
  logic                err_q;

  logic [NumPorts-1:0] eligible;
  logic [NumPorts-1:0] grant;
  logic [PortIdW-1:0]  grant_idx;
  logic                grant_vld;
  logic                load;
  tagged_tid_t         rtrn_tag;
  logic [NumPorts-1:0] rtrn_hit;
  logic                rtrn_bad;

  always_comb begin
    eligible = '0;
    for (int p = 0; p < NumPorts; p++)
      eligible[p] = req_i[p] & (cnt_q[p] < cnt_t'(MaxOutstanding)) & ~stall_i;
  end

  wt_mem_arb_rr #(
    .NumPorts (NumPorts),
    .IdxW     (PortIdW)
  ) i_rr (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // The stage reloads in the same cycle the adapter takes the current entry.
  assign load  = grant_vld & (~valid_q | mem_ack_i) & ~rst_i;
  assign ack_o = {NumPorts{load}} & grant;

  assign rtrn_tag = tagged_tid_t'(mem_rtrn_tid_i);

  // Returns for an unknown port or a port with no credit in use are dropped and flagged.
  always_comb begin
    rtrn_hit = '0;
    rtrn_bad = 1'b0;
    if (mem_rtrn_vld_i && !rst_i) begin
      if (int'(rtrn_tag.port) >= NumPorts)
        rtrn_bad = 1'b1;
      else if (cnt_q[rtrn_tag.port] == '0)
        rtrn_bad = 1'b1;
      else
        rtrn_hit[rtrn_tag.port] = 1'b1;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ptr_q   <= PortIdW'(NumPorts - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (load) begin
        valid_q <= 1'b1;
        ptr_q   <= grant_idx;
      end else if (mem_ack_i) begin
        valid_q <= 1'b0;
      end
      for (int p = 0; p < NumPorts; p++)
        cnt_q[p] <= cnt_q[p] + cnt_t'(ack_o[p]) - cnt_t'(rtrn_hit[p]);
      if (rtrn_bad) err_q <= 1'b1;
    end
  end

  // NOTE: the payload register is left unreset; it is only observed while valid_q is set.
  always_ff @(posedge clk_i) begin
    if (load) begin
      data_q <= data_i[grant_idx];
      tag_q  <= '{port: grant_idx, tid: tid_i[grant_idx]};
    end
  end

  assign mem_req_o   = valid_q;
  assign mem_data_o  = data_q;
  assign mem_tid_o   = tag_q;
  assign rtrn_vld_o  = rtrn_hit;
  assign rtrn_tid_o  = rtrn_tag.tid;
  assign rtrn_data_o = mem_rtrn_data_i;
  assign busy_o      = valid_q | (|cnt_q);
  assign err_o       = err_q;

  ack_onehot_a : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ack_o));
  rtrn_onehot_a : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rtrn_vld_o));

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Self-checking bench for wt_mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_wt_mem_arbiter;

  localparam int NP   = 3;
  localparam int RW   = 16;
  localparam int RTW  = 16;
  localparam int TW   = 2;
  localparam int MAXO = 4;
  localparam int PW   = 2;
  localparam int GW   = PW + TW;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   stall = 1'b0;
  logic                   busy, err;
  logic [NP-1:0]          req = '0;
  logic [NP-1:0]          ack;
  logic [NP-1:0][RW-1:0]  data = '0;
  logic [NP-1:0][TW-1:0]  tid = '0;
  logic                   mem_req;
  logic                   mem_ack = 1'b0;
  logic [RW-1:0]          mem_data;
  logic [GW-1:0]          mem_tid;
  logic                   rvld = 1'b0;
  logic [GW-1:0]          rtag = '0;
  logic [RTW-1:0]         rdata = '0;
  logic [NP-1:0]          rtrn_vld;
  logic [TW-1:0]          rtrn_tid;
  logic [RTW-1:0]         rtrn_data;

  always #5 clk = ~clk;

  wt_mem_arbiter #(
    .NumPorts       (NP),
    .ReqWidth       (RW),
    .RtrnWidth      (RTW),
    .TidWidth       (TW),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .busy_o          (busy),
    .err_o           (err),
    .req_i           (req),
    .ack_o           (ack),
    .data_i          (data),
    .tid_i           (tid),
    .mem_req_o       (mem_req),
    .mem_ack_i       (mem_ack),
    .mem_data_o      (mem_data),
    .mem_tid_o       (mem_tid),
    .mem_rtrn_vld_i  (rvld),
    .mem_rtrn_tid_i  (rtag),
    .mem_rtrn_data_i (rdata),
    .rtrn_vld_o      (rtrn_vld),
    .rtrn_tid_o      (rtrn_tid),
    .rtrn_data_o     (rtrn_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stage contents, in-flight count per client, last winner, sticky error,
  // and the tags the adapter has accepted but not yet returned.
  bit            m_valid;
  logic [RW-1:0] m_data;
  int            m_tag;
  int            m_cnt[NP];
  int            m_last;
  bit            m_err;
  int            acc_q[$];

  logic [NP-1:0] pend;
  logic [NP-1:0] obs_ack, obs_rvld;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cnt_sum();
    int s = 0;
    for (int p = 0; p < NP; p++) s += m_cnt[p];
    return s;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_tag   = 0;
    for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    m_last  = NP - 1;
    m_err   = 1'b0;
    acc_q.delete();
    pend    = '0;
  endtask

  task automatic set_rtrn(input int tag);
    rvld  = 1'b1;
    rtag  = GW'(tag);
    rdata = RTW'($urandom);
  endtask

  // One clock: drive requests, compare outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int w, rp, p;
    bit rerr;
    logic [NP-1:0] eack, ervld;
    req = pend;
    @(negedge clk);
    w = -1;
    for (int k = 1; k <= NP; k++) begin
      p = (m_last + k) % NP;
      if (w < 0 && req[p] && m_cnt[p] < MAXO && !stall) w = p;
    end
    eack = '0;
    if (w >= 0 && (!m_valid || mem_ack)) eack[w] = 1'b1;
    ervld = '0;
    rerr  = 1'b0;
    rp    = int'(rtag) >> TW;
    if (rvld) begin
      if (rp < NP && m_cnt[rp] > 0) ervld[rp] = 1'b1;
      else rerr = 1'b1;
    end
    obs_ack  = ack;
    obs_rvld = rtrn_vld;
    check("ack", ack, eack);
    check("rtrn_vld", rtrn_vld, ervld);
    check("rtrn_tid", rtrn_tid, rtag[TW-1:0]);
    check("rtrn_data", rtrn_data, rdata);
    check("mem_req", mem_req, m_valid);
    if (m_valid) begin
      check("mem_data", mem_data, m_data);
      check("mem_tid", mem_tid, m_tag);
    end
    check("busy", busy, (m_valid || cnt_sum() > 0));
    check("err", err, m_err);
    @(posedge clk);
    if (m_valid && mem_ack) acc_q.push_back(m_tag);
    if (ervld != '0) begin
      m_cnt[rp]--;
      for (int i = 0; i < acc_q.size(); i++)
        if (acc_q[i] == int'(rtag)) begin
          acc_q.delete(i);
          break;
        end
    end
    if (eack != '0) begin
      m_valid = 1'b1;
      m_data  = data[w];
      m_tag   = (w << TW) | int'(tid[w]);
      m_cnt[w]++;
      m_last  = w;
      pend[w] = 1'b0;
    end else if (mem_ack) begin
      m_valid = 1'b0;
    end
    if (rerr) m_err = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pend = '0; req = '0; rvld = 1'b0; stall = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_ack", ack, 0);
    check("rst_rvld", rtrn_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drain: adapter accepts everything, outstanding tags come back in random order.
  task automatic settle();
    int n = 0;
    stall = 1'b0; mem_ack = 1'b1;
    while ((m_valid || acc_q.size() > 0 || pend != '0) && n < 300) begin
      if (acc_q.size() > 0) set_rtrn(acc_q[$urandom_range(acc_q.size() - 1)]);
      else rvld = 1'b0;
      cycle();
      n++;
    end
    rvld = 1'b0; mem_ack = 1'b0;
    check("settle_done", (m_valid || acc_q.size() > 0 || pend != '0), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [RW-1:0] saved;
    int            t;
    model_reset();
    do_reset();

    // First grant after reset goes to port 0
    data[0] = 16'h1111; tid[0] = 2'd3;
    data[1] = 16'h2222; tid[1] = 2'd1;
    pend = 3'b011; mem_ack = 1'b0;
    cycle();
    check("first_ack", obs_ack, 3'b001);
    check("first_req", mem_req, 1);
    check("first_tid", mem_tid, 4'b0011);
    check("first_busy", busy, 1);
    settle();

    // Fairness: ports 0 and 1 alternate until both hit the credit limit
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pend = 3'b011;
      cycle();
      check($sformatf("fair_%0d", i), obs_ack, (i % 2 == 0) ? 3'b001 : 3'b010);
    end
    pend = 3'b011;
    cycle();
    check("fair_full", obs_ack, 3'b000);
    pend = '0;
    settle();

    // Outstanding limit on port 0
    mem_ack = 1'b1;
    for (int i = 0; i < MAXO; i++) begin
      pend = 3'b001; data[0] = RW'($urandom);
      cycle();
      check($sformatf("limit_%0d", i), obs_ack, 3'b001);
    end
    pend = 3'b001;
    cycle();
    check("limit_block", obs_ack, 3'b000);
    set_rtrn(acc_q[0]);
    cycle();
    check("limit_rtrn_cycle", obs_ack, 3'b000);
    rvld = 1'b0;
    cycle();
    check("limit_after_rtrn", obs_ack, 3'b001);
    settle();

    // Stall holds the loaded request and blocks new grants
    pend = 3'b100; data[2] = 16'hBEEF; mem_ack = 1'b0;
    cycle();
    check("stall_load", obs_ack, 3'b100);
    saved = data[2];
    stall = 1'b1; pend = 3'b011;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("stall_ack_%0d", i), obs_ack, 3'b000);
      check($sformatf("stall_req_%0d", i), mem_req, 1);
      check($sformatf("stall_data_%0d", i), mem_data, saved);
    end
    stall = 1'b0; mem_ack = 1'b1;
    cycle();
    check("stall_release", obs_ack, 3'b001);
    settle();

    // Return routing to port 2
    pend = 3'b100; tid[2] = 2'd1; data[2] = RW'($urandom); mem_ack = 1'b1;
    cycle();
    cycle();
    set_rtrn(4'b1001);
    cycle();
    check("route_vld", obs_rvld, 3'b100);
    check("route_tid", rtrn_tid, 2'd1);
    rvld = 1'b0;
    settle();

    // Grant and return on port 1 in the same cycle with two in flight
    mem_ack = 1'b1;
    pend = 3'b010; cycle();
    pend = 3'b010; cycle();
    cycle();
    pend = 3'b010; set_rtrn(acc_q[0]);
    cycle();
    check("sim_ack", obs_ack, 3'b010);
    check("sim_rvld", obs_rvld, 3'b010);
    set_rtrn(acc_q[0]);
    cycle();
    check("sim_busy_mid", busy, 1);
    set_rtrn(acc_q[0]);
    cycle();
    check("sim_rvld_last", obs_rvld, 3'b010);
    check("sim_busy_end", busy, 0);
    rvld = 1'b0; mem_ack = 1'b0;

    // Error: return on a port with no credit in use
    set_rtrn(4'b0000);
    cycle();
    check("err_cnt0_vld", obs_rvld, 3'b000);
    check("err_cnt0", err, 1);
    rvld = 1'b0;
    cycle();
    check("err_sticky", err, 1);
    do_reset();

    // Error: return with an out-of-range port field
    set_rtrn(4'b1100);
    cycle();
    check("err_port3_vld", obs_rvld, 3'b000);
    check("err_port3", err, 1);
    rvld = 1'b0;
    repeat (3) cycle();
    check("err_port3_sticky", err, 1);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++)
        if (!pend[p] && $urandom_range(2) == 0) begin
          pend[p] = 1'b1;
          data[p] = RW'($urandom);
          tid[p]  = TW'($urandom);
        end
      stall   = ($urandom_range(7) == 0);
      mem_ack = 1'($urandom_range(1));
      if (acc_q.size() > 0 && $urandom_range(1) == 1)
        set_rtrn(acc_q[$urandom_range(acc_q.size() - 1)]);
      else begin
        rvld = 1'b0;
        rtag = GW'($urandom);
      end
      cycle();
    end
    settle();

    // Reset with a transaction in flight; its late return is flagged
    pend = 3'b001; mem_ack = 1'b1;
    cycle();
    cycle();
    t = acc_q[0];
    do_reset();
    set_rtrn(t);
    cycle();
    check("post_rst_rtrn_vld", obs_rvld, 3'b000);
    check("post_rst_err", err, 1);
    rvld = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
